ps2_key_decoder: RTL and testbench

//   Consumes the scan-code byte stream from ps2_keyboard (ready/nextdata_n FIFO handshake)
//   and decodes PS/2 set-2 make/break/extended sequences into a held-key state: last key

---
 rtl/ps2_key_decoder.sv | 127 ++++++++++++
 tb/tb_ps2_key_decoder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
`timescale 1ns/1ps
// PS/2 set-2 scan-code decoder: make/break/E0 sequences -> held key, ASCII, press count.
// Outputs update one cycle after a byte is consumed; pops at most one byte every 2 cycles.
module ps2_key_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             ready,
  input  logic             overflow,
  input  logic [7:0]       data,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic [7:0]       key_ascii,
  output logic             key_valid,
  output logic             key_event,
  output logic [CNT_W-1:0] key_count,
  output logic             ovf_sticky
);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t state, state_nxt;
  logic   take;
  logic   do_make, do_brk, code_ext;
  logic   same_key, new_press, release_key;

  // ready is only looked at while the previous pop strobe has been retired
  assign take = ready & nextdata_n;

  function automatic logic [7:0] set2_ascii(input logic [7:0] c);
    logic [7:0] a;
    a = 8'h00;
    case (c)
      8'h1C: a = 8'h61; 8'h32: a = 8'h62; 8'h21: a = 8'h63; 8'h23: a = 8'h64;
      8'h24: a = 8'h65; 8'h2B: a = 8'h66; 8'h34: a = 8'h67; 8'h33: a = 8'h68;
      8'h43: a = 8'h69; 8'h3B: a = 8'h6A; 8'h42: a = 8'h6B; 8'h4B: a = 8'h6C;
      8'h3A: a = 8'h6D; 8'h31: a = 8'h6E; 8'h44: a = 8'h6F; 8'h4D: a = 8'h70;
      8'h15: a = 8'h71; 8'h2D: a = 8'h72; 8'h1B: a = 8'h73; 8'h2C: a = 8'h74;
      8'h3C: a = 8'h75; 8'h2A: a = 8'h76; 8'h1D: a = 8'h77; 8'h22: a = 8'h78;
      8'h35: a = 8'h79; 8'h1A: a = 8'h7A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20; 8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    do_make     = 1'b0;
    do_brk      = 1'b0;
    code_ext    = 1'b0;
    same_key    = 1'b0;
    new_press   = 1'b0;
    release_key = 1'b0;
    if (take) begin
      case (state)
        IDLE: begin
          if (data == CODE_EXT)      state_nxt = EXT;
          else if (data == CODE_BRK) state_nxt = BRK;
          else                       do_make   = 1'b1;
        end
        EXT: begin
          if (data == CODE_BRK) state_nxt = EXT_BRK;
          else if (data != CODE_EXT) begin
            do_make   = 1'b1;
            code_ext  = 1'b1;
            state_nxt = IDLE;
          end
        end
        BRK: begin
          do_brk    = 1'b1;
          state_nxt = IDLE;
        end
        EXT_BRK: begin
          do_brk    = 1'b1;
          code_ext  = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
    // a make of the already-held key is typematic repeat
    same_key    = key_valid && (data == key_code) && (code_ext == key_ext);
    new_press   = do_make && !same_key;
    release_key = do_brk && same_key;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      nextdata_n <= 1'b1;
      key_code   <= 8'h00;
      key_ext    <= 1'b0;
      key_ascii  <= 8'h00;
      key_valid  <= 1'b0;
      key_event  <= 1'b0;
      key_count  <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      nextdata_n <= ~take;
      key_event  <= new_press;
      if (new_press) begin
        key_code  <= data;
        key_ext   <= code_ext;
        key_ascii <= code_ext ? 8'h00 : set2_ascii(data);
        key_valid <= 1'b1;
        key_count <= key_count + 1'b1;
      end else if (release_key) begin
        key_valid <= 1'b0;
      end
      if (overflow) ovf_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
`timescale 1ns/1ps
// Bench for ps2_key_decoder: FIFO source, sequence-level reference model, per-cycle compare.
module tb_ps2_key_decoder;

  logic clk, clrn, ready, overflow;
  logic [7:0] data;

  logic       nd8, ext8, valid8, ev8, ovf8;
  logic [7:0] code8, ascii8, cnt8;
  logic       nd2, ext2, valid2, ev2, ovf2;
  logic [7:0] code2, ascii2;
  logic [1:0] cnt2;

  ps2_key_decoder #(.CNT_W(8)) dut8 (
    .clk(clk), .clrn(clrn), .ready(ready), .overflow(overflow), .data(data),
    .nextdata_n(nd8), .key_code(code8), .key_ext(ext8), .key_ascii(ascii8),
    .key_valid(valid8), .key_event(ev8), .key_count(cnt8), .ovf_sticky(ovf8));

  ps2_key_decoder #(.CNT_W(2)) dut2 (
    .clk(clk), .clrn(clrn), .ready(ready), .overflow(overflow), .data(data),
    .nextdata_n(nd2), .key_code(code2), .key_ext(ext2), .key_ascii(ascii2),
    .key_valid(valid2), .key_event(ev2), .key_count(cnt2), .ovf_sticky(ovf2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo[$];
  logic [7:0] seq[$];
  logic [7:0] amap[256];

  // reference model state
  logic [7:0] m_code, m_ascii;
  logic       m_ext, m_valid, m_event, m_ovf, m_ndn;
  int         m_count;

  logic       s_clrn, s_ready, s_ovf;
  logic [7:0] s_data;

  int  ev_cnt, low_cnt, last_low, cyc;
  bit  track_gap;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_code = 0; m_ascii = 0; m_ext = 0; m_valid = 0; m_event = 0;
    m_ovf = 0; m_ndn = 1; m_count = 0;
    seq.delete();
  endtask

  task automatic m_make(input logic [7:0] c, input logic e);
    if (m_valid && c == m_code && e == m_ext) return;
    m_code = c; m_ext = e; m_ascii = e ? 8'h00 : amap[c];
    m_valid = 1; m_event = 1; m_count++;
  endtask

  task automatic m_break(input logic [7:0] c, input logic e);
    if (m_valid && c == m_code && e == m_ext) m_valid = 0;
  endtask

  // interpret the accumulated byte sequence once it forms a complete message
  task automatic m_feed(input logic [7:0] b);
    int i;
    bit e;
    seq.push_back(b);
    i = 0; e = 0;
    while (i < seq.size() && seq[i] == 8'hE0) begin e = 1; i++; end
    if (i == seq.size()) return;
    if (seq[i] == 8'hF0) begin
      if (seq.size() == i + 2) begin
        m_break(seq[i+1], e);
        seq.delete();
      end
      return;
    end
    m_make(seq[i], e);
    seq.delete();
  endtask

  task automatic tick();
    ready = (fifo.size() != 0);
    data  = ready ? fifo[0] : 8'h00;
    s_clrn = clrn; s_ready = ready; s_data = data; s_ovf = overflow;
    @(negedge clk);
    cyc++;
    if (!s_clrn || !clrn) m_reset();
    else begin
      m_event = 0;
      if (s_ovf) m_ovf = 1;
      if (s_ready && m_ndn) begin
        m_ndn = 0;
        m_feed(s_data);
      end else m_ndn = 1;
    end
    chk("nextdata_n", nd8, m_ndn);
    chk("key_code", code8, m_code);
    chk("key_ext", ext8, m_ext);
    chk("key_ascii", ascii8, m_ascii);
    chk("key_valid", valid8, m_valid);
    chk("key_event", ev8, m_event);
    chk("key_count", cnt8, m_count % 256);
    chk("ovf_sticky", ovf8, m_ovf);
    chk("nextdata_n_w2", nd2, m_ndn);
    chk("key_valid_w2", valid2, m_valid);
    chk("key_count_w2", cnt2, m_count % 4);
    if (ev8) ev_cnt++;
    if (!nd8) begin
      low_cnt++;
      if (track_gap && last_low >= 0) chk("pop_gap", cyc - last_low, 2);
      last_low = cyc;
      fifo.pop_front();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((fifo.size() != 0 || !nd8) && n < 100) begin tick(); n++; end
    chk("drain_done", fifo.size(), 0);
    tick(); tick();
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic do_reset();
    clrn = 0; tick(); tick(); clrn = 1; tick();
  endtask

  initial begin
    logic [7:0] lc[26];
    logic [7:0] dc[10];
    logic [7:0] k5[4];
    lc = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
           8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    dc = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    k5 = '{8'h16,8'h1E,8'h26,8'h25};
    for (int i = 0; i < 256; i++) amap[i] = 8'h00;
    for (int i = 0; i < 26; i++) amap[lc[i]] = 8'h61 + 8'(i);
    for (int i = 0; i < 10; i++) amap[dc[i]] = 8'h30 + 8'(i);
    amap[8'h29] = 8'h20;
    amap[8'h5A] = 8'h0D;

    m_reset();
    ev_cnt = 0; low_cnt = 0; last_low = -1; cyc = 0; track_gap = 0;
    clrn = 0; overflow = 0; ready = 0; data = 0;

    // 1: reset holds off pops even with data waiting
    push(8'h1C);
    repeat (4) tick();
    chk("t1_no_pop", fifo.size(), 1);
    chk("t1_ndn", nd8, 1);
    chk("t1_count", cnt8, 0);
    clrn = 1;
    drain();

    // 2: press and release 'a'
    chk("t2_valid", valid8, 1);
    chk("t2_code", code8, 8'h1C);
    chk("t2_ascii", ascii8, 8'h61);
    chk("t2_count", cnt8, 1);
    push(8'hF0); push(8'h1C);
    drain();
    chk("t2_rel_valid", valid8, 0);
    chk("t2_rel_code", code8, 8'h1C);
    chk("t2_rel_count", cnt8, 1);

    // 3: typematic repeats with ready held high
    do_reset();
    ev_cnt = 0; low_cnt = 0; last_low = -1; track_gap = 1;
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    drain();
    track_gap = 0;
    chk("t3_events", ev_cnt, 1);
    chk("t3_pops", low_cnt, 5);
    chk("t3_count", cnt8, 1);
    chk("t3_valid", valid8, 0);

    // 4: extended key, non-extended break ignored, extended break releases
    push(8'hE0); push(8'h75);
    drain();
    chk("t4_ext", ext8, 1);
    chk("t4_code", code8, 8'h75);
    chk("t4_ascii", ascii8, 8'h00);
    chk("t4_valid", valid8, 1);
    push(8'hF0); push(8'h75);
    drain();
    chk("t4_plain_brk", valid8, 1);
    push(8'hE0); push(8'hF0); push(8'h75);
    drain();
    chk("t4_ext_brk", valid8, 0);
    push(8'hE0); push(8'hE0); push(8'h5A);
    drain();
    chk("t4_ee_ext", ext8, 1);
    push(8'h29);
    drain();
    chk("t4_space", ascii8, 8'h20);
    push(8'h5A);
    drain();
    chk("t4_enter", ascii8, 8'h0D);
    push(8'hF0); push(8'hE0);
    drain();
    chk("t4_brk_e0", valid8, 1);

    // 5: narrow counter wraps
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(k5[i]);
      drain();
      chk("t5_count_w2", cnt2, (i + 1) % 4);
      chk("t5_ascii", ascii8, 8'h31 + i);
      push(8'hF0); push(k5[i]);
      drain();
      chk("t5_released", valid8, 0);
    end

    // 6: reset discards a pending break prefix; overflow is sticky
    do_reset();
    push(8'hF0);
    drain();
    do_reset();
    push(8'h1C);
    drain();
    chk("t6_make_after_rst", valid8, 1);
    overflow = 1; tick(); overflow = 0;
    repeat (3) tick();
    chk("t6_ovf_set", ovf8, 1);
    do_reset();
    chk("t6_ovf_clr", ovf8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
